// File: rtl/wb_to_axil_bridge.sv
// Wishbone classic slave to AXI4-Lite master bridge.
// One access in flight at a time; each Wishbone cycle becomes exactly one AXI read or write.
module wb_to_axil_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] i_wb_adr,
  input  logic [STRB_WIDTH-1:0] i_wb_sel,
  input  logic                  i_wb_we,
  input  logic [DATA_WIDTH-1:0] i_wb_dat,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  output logic [DATA_WIDTH-1:0] o_wb_dat,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R, DONE} state_t;

  state_t                r_state,   w_state_next;
  logic [ADDR_WIDTH-1:0] r_adr,     w_adr_next;
  logic [DATA_WIDTH-1:0] r_wdata,   w_wdata_next;
  logic [STRB_WIDTH-1:0] r_wstrb,   w_wstrb_next;
  logic [DATA_WIDTH-1:0] r_rdata,   w_rdata_next;
  logic                  r_awvalid, w_awvalid_next;
  logic                  r_wvalid,  w_wvalid_next;
  logic                  r_bready,  w_bready_next;
  logic                  r_arvalid, w_arvalid_next;
  logic                  r_rready,  w_rready_next;
  logic                  r_ack,     w_ack_next;
  logic                  r_err,     w_err_next;
  logic                  w_aw_done;
  logic                  w_w_done;

  // NOTE: every register bit gets a default before the case so no path leaves a latch.
  always_comb begin
    w_state_next   = r_state;
    w_adr_next     = r_adr;
    w_wdata_next   = r_wdata;
    w_wstrb_next   = r_wstrb;
    w_rdata_next   = r_rdata;
    w_awvalid_next = r_awvalid;
    w_wvalid_next  = r_wvalid;
    w_bready_next  = r_bready;
    w_arvalid_next = r_arvalid;
    w_rready_next  = r_rready;
    w_ack_next     = 1'b0;
    w_err_next     = 1'b0;
    // A channel is finished once its valid is low or is being accepted on this edge.
    w_aw_done      = ~r_awvalid | m_axil_awready;
    w_w_done       = ~r_wvalid  | m_axil_wready;

    unique case (r_state)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          w_adr_next   = i_wb_adr;
          w_wdata_next = i_wb_dat;
          w_wstrb_next = i_wb_sel;
          if (i_wb_we) begin
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
            w_bready_next  = 1'b1;
            w_state_next   = WR;
          end else begin
            w_arvalid_next = 1'b1;
            w_state_next   = RD;
          end
        end
      end
      WR: begin
        if (m_axil_awready) w_awvalid_next = 1'b0;
        if (m_axil_wready)  w_wvalid_next  = 1'b0;
        // bready is already high here, so a B arriving with the last handshake is taken.
        if (w_aw_done && w_w_done) begin
          if (m_axil_bvalid) begin
            w_bready_next = 1'b0;
            w_ack_next    = (m_axil_bresp == 2'b00);
            w_err_next    = (m_axil_bresp != 2'b00);
            w_state_next  = DONE;
          end else begin
            w_state_next  = WAIT_B;
          end
        end
      end
      WAIT_B: begin
        if (m_axil_bvalid) begin
          w_bready_next = 1'b0;
          w_ack_next    = (m_axil_bresp == 2'b00);
          w_err_next    = (m_axil_bresp != 2'b00);
          w_state_next  = DONE;
        end
      end
      RD: begin
        if (m_axil_arready) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_state_next   = WAIT_R;
        end
      end
      WAIT_R: begin
        if (m_axil_rvalid) begin
          w_rready_next = 1'b0;
          w_rdata_next  = m_axil_rdata;
          w_ack_next    = (m_axil_rresp == 2'b00);
          w_err_next    = (m_axil_rresp != 2'b00);
          w_state_next  = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_adr     <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_adr     <= w_adr_next;
      r_wdata   <= w_wdata_next;
      r_wstrb   <= w_wstrb_next;
      r_rdata   <= w_rdata_next;
      r_awvalid <= w_awvalid_next;
      r_wvalid  <= w_wvalid_next;
      r_bready  <= w_bready_next;
      r_arvalid <= w_arvalid_next;
      r_rready  <= w_rready_next;
      r_ack     <= w_ack_next;
      r_err     <= w_err_next;
    end
  end

  assign o_wb_dat       = r_rdata;
  assign o_wb_ack       = r_ack;
  assign o_wb_err       = r_err;
  assign m_axil_awaddr  = r_adr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = r_bready;
  assign m_axil_araddr  = r_adr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_wb_to_axil_bridge.sv
// Testbench for wb_to_axil_bridge: configurable AXI4-Lite SRAM/stub slave,
// protocol monitor and a scoreboard of expected Wishbone responses.
module tb_wb_to_axil_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] i_wb_adr = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        i_wb_we  = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack, o_wb_err;

  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic        m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_bvalid = 1'b0;
  logic        m_axil_arready = 1'b0, m_axil_rvalid = 1'b0;
  logic [1:0]  m_axil_bresp = 2'b00, m_axil_rresp = 2'b00;
  logic [31:0] m_axil_rdata = '0;

  wb_to_axil_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed { logic err; logic [31:0] dat; } exp_t;
  exp_t        sb[$];
  logic [31:0] exp_mem [16];
  logic [31:0] model_dat = '0;
  int          n_wr = 0;
  int          n_rd = 0;

  task automatic push_exp(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input logic exp_err,
                          input logic force_rd, input logic [31:0] forced);
    exp_t e;
    if (we) begin
      n_wr++;
      if (!exp_err) exp_mem[adr[5:2]] = merge(exp_mem[adr[5:2]], dat, sel);
    end else begin
      n_rd++;
      model_dat = force_rd ? forced : exp_mem[adr[5:2]];
    end
    e.err = exp_err;
    e.dat = model_dat;
    sb.push_back(e);
  endtask

  // ---------------- AXI4-Lite slave (SRAM with stub knobs) ----------------
  logic [31:0] mem [16];
  int          cfg_aw_lat = 0, cfg_w_lat = 0, cfg_ar_lat = 0, cfg_r_lat = 0;
  logic        cfg_b_early = 1'b0, cfg_rforce = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  logic        have_aw = 0, have_w = 0, have_ar = 0, b_issued = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  // Handshakes that will complete (or just completed) on the posedge after the last negedge.
  logic        f_aw = 0, f_w = 0, f_b = 0, f_ar = 0, f_r = 0;

  task automatic slave_step();
    if (rst) begin
      m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
      m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rresp = 0; m_axil_rdata = 0;
      have_aw = 0; have_w = 0; have_ar = 0; b_issued = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
      return;
    end
    if (f_aw) begin m_axil_awready = 0; have_aw = 1; end
    if (f_w)  begin m_axil_wready  = 0; have_w  = 1; end
    if (f_b)  begin m_axil_bvalid  = 0; b_issued = 0; have_aw = 0; have_w = 0; end
    if (f_ar) begin m_axil_arready = 0; have_ar = 1; r_cnt = 0; end
    if (f_r)  begin m_axil_rvalid  = 0; have_ar = 0; end

    if (m_axil_awvalid && !have_aw && !m_axil_awready) begin
      if (aw_cnt >= cfg_aw_lat) begin m_axil_awready = 1; aw_cnt = 0; s_awaddr = m_axil_awaddr; end
      else aw_cnt++;
    end
    if (m_axil_wvalid && !have_w && !m_axil_wready) begin
      if (w_cnt >= cfg_w_lat) begin
        m_axil_wready = 1; w_cnt = 0; s_wdata = m_axil_wdata; s_wstrb = m_axil_wstrb;
      end else w_cnt++;
    end
    if (!b_issued && ((have_aw && have_w) ||
        (cfg_b_early && (have_aw || m_axil_awready) && (have_w || m_axil_wready)))) begin
      if (cfg_bresp == 2'b00) mem[s_awaddr[5:2]] = merge(mem[s_awaddr[5:2]], s_wdata, s_wstrb);
      m_axil_bresp = cfg_bresp; m_axil_bvalid = 1; b_issued = 1;
    end

    if (m_axil_arvalid && !have_ar && !m_axil_arready) begin
      if (ar_cnt >= cfg_ar_lat) begin m_axil_arready = 1; ar_cnt = 0; s_araddr = m_axil_araddr; end
      else ar_cnt++;
    end
    if (have_ar && !m_axil_rvalid) begin
      if (r_cnt >= cfg_r_lat) begin
        m_axil_rvalid = 1;
        m_axil_rdata  = cfg_rforce ? cfg_rdata : mem[s_araddr[5:2]];
        m_axil_rresp  = cfg_rresp;
      end else r_cnt++;
    end

    f_aw = m_axil_awvalid && m_axil_awready;
    f_w  = m_axil_wvalid  && m_axil_wready;
    f_b  = m_axil_bvalid  && m_axil_bready;
    f_ar = m_axil_arvalid && m_axil_arready;
    f_r  = m_axil_rvalid  && m_axil_rready;
  endtask

  // ---------------- protocol monitor + scoreboard compare ----------------
  logic        p_awvalid = 0, p_wvalid = 0, p_arvalid = 0, p_resp = 0, busy = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;
  int          cyc_n = 0, last_resp_cyc = -1;
  int          n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0, n_ar_hs = 0, n_r_hs = 0;

  task automatic monitor_step();
    exp_t e;
    cyc_n++;
    if (rst) begin
      p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_resp = 0; busy = 0;
      return;
    end
    if (f_aw) n_aw_hs++;
    if (f_w)  n_w_hs++;
    if (f_b)  n_b_hs++;
    if (f_ar) n_ar_hs++;
    if (f_r)  n_r_hs++;

    if (p_awvalid && !f_aw) begin
      check("aw_hold", 32'(m_axil_awvalid), 32'd1);
      check("aw_addr_stable", m_axil_awaddr, p_awaddr);
    end
    if (f_aw) check("aw_drop", 32'(m_axil_awvalid), 32'd0);
    if (p_wvalid && !f_w) begin
      check("w_hold", 32'(m_axil_wvalid), 32'd1);
      check("w_data_stable", m_axil_wdata, p_wdata);
      check("w_strb_stable", 32'(m_axil_wstrb), 32'(p_wstrb));
    end
    if (f_w) check("w_drop", 32'(m_axil_wvalid), 32'd0);
    if (p_arvalid && !f_ar) begin
      check("ar_hold", 32'(m_axil_arvalid), 32'd1);
      check("ar_addr_stable", m_axil_araddr, p_araddr);
    end
    if (f_ar) check("ar_drop", 32'(m_axil_arvalid), 32'd0);
    if (m_axil_awvalid) check("awprot", 32'(m_axil_awprot), 32'd0);
    if (m_axil_arvalid) check("arprot", 32'(m_axil_arprot), 32'd0);

    if ((m_axil_awvalid && !p_awvalid) || (m_axil_arvalid && !p_arvalid)) begin
      check("no_overlap", 32'(busy), 32'd0);
      busy = 1;
    end

    if (o_wb_ack || o_wb_err) begin
      check("ack_err_exclusive", 32'(o_wb_ack & o_wb_err), 32'd0);
      check("resp_one_cycle", 32'(p_resp), 32'd0);
      if (last_resp_cyc >= 0) check("resp_gap_ge2", 32'((cyc_n - last_resp_cyc) >= 2), 32'd1);
      last_resp_cyc = cyc_n;
      busy = 0;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wb_err", 32'(o_wb_err), 32'(e.err));
        check("wb_ack", 32'(o_wb_ack), 32'(!e.err));
        check("wb_dat", o_wb_dat, e.dat);
      end
    end

    p_resp    = o_wb_ack | o_wb_err;
    p_awvalid = m_axil_awvalid; p_awaddr = m_axil_awaddr;
    p_wvalid  = m_axil_wvalid;  p_wdata  = m_axil_wdata; p_wstrb = m_axil_wstrb;
    p_arvalid = m_axil_arvalid; p_araddr = m_axil_araddr;
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
    slave_step();
  end

  // ---------------- Wishbone driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    i_wb_we = we; i_wb_adr = adr; i_wb_sel = sel; i_wb_dat = dat;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
  endtask

  task automatic wait_resp(output bit got);
    got = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (o_wb_ack || o_wb_err) begin got = 1; break; end
    end
    check("wb_resp_seen", 32'(got), 32'd1);
    if (!got && sb.size() > 0) sb.delete(sb.size() - 1);
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic exp_err,
                           input logic force_rd, input logic [31:0] forced);
    bit got;
    drive(we, adr, sel, dat);
    push_exp(we, adr, sel, dat, exp_err, force_rd, forced);
    wait_resp(got);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_awvalid"}, 32'(m_axil_awvalid), 32'd0);
    check({pfx, "_wvalid"},  32'(m_axil_wvalid),  32'd0);
    check({pfx, "_bready"},  32'(m_axil_bready),  32'd0);
    check({pfx, "_arvalid"}, 32'(m_axil_arvalid), 32'd0);
    check({pfx, "_rready"},  32'(m_axil_rready),  32'd0);
    check({pfx, "_ack"},     32'(o_wb_ack),       32'd0);
    check({pfx, "_err"},     32'(o_wb_err),       32'd0);
    check({pfx, "_wb_dat"},  o_wb_dat,            32'd0);
    check({pfx, "_awaddr"},  m_axil_awaddr,       32'd0);
    check({pfx, "_wdata"},   m_axil_wdata,        32'd0);
    check({pfx, "_wstrb"},   32'(m_axil_wstrb),   32'd0);
    check({pfx, "_state"},   32'(dut.r_state),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; exp_mem[i] = '0; end

    rst = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    check("reset_awprot", 32'(m_axil_awprot), 32'd0);
    check("reset_arprot", 32'(m_axil_arprot), 32'd0);
    rst = 1'b0;
    tick();

    // Full write then read-back through the SRAM.
    wb_access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, '0);
    tick();
    check("first_wr_aw_hs", 32'(n_aw_hs), 32'd1);
    check("first_wr_w_hs",  32'(n_w_hs),  32'd1);
    check("first_wr_b_hs",  32'(n_b_hs),  32'd1);
    wb_access(1'b0, 32'h10, 4'h0, '0, 1'b0, 1'b0, '0);

    // Byte-lane write.
    wb_access(1'b1, 32'h10, 4'b0010, 32'h0000AB00, 1'b0, 1'b0, '0);
    wb_access(1'b0, 32'h10, 4'h0, '0, 1'b0, 1'b0, '0);

    // AW accepted well before W, then the reverse; slow R path for the read-backs.
    cfg_aw_lat = 0; cfg_w_lat = 3;
    wb_access(1'b1, 32'h20, 4'hF, 32'h11112222, 1'b0, 1'b0, '0);
    cfg_aw_lat = 3; cfg_w_lat = 0;
    wb_access(1'b1, 32'h24, 4'b1100, 32'h33334444, 1'b0, 1'b0, '0);
    cfg_aw_lat = 0; cfg_r_lat = 2;
    wb_access(1'b0, 32'h20, 4'h0, '0, 1'b0, 1'b0, '0);
    wb_access(1'b0, 32'h24, 4'h0, '0, 1'b0, 1'b0, '0);
    cfg_r_lat = 0;

    // B presented together with the final AW/W handshake.
    cfg_b_early = 1'b1;
    wb_access(1'b1, 32'h08, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, '0);
    cfg_aw_lat = 2;
    wb_access(1'b1, 32'h0C, 4'hF, 32'h0BADCAFE, 1'b0, 1'b0, '0);
    cfg_b_early = 1'b0; cfg_aw_lat = 0;
    wb_access(1'b0, 32'h08, 4'h0, '0, 1'b0, 1'b0, '0);
    wb_access(1'b0, 32'h0C, 4'h0, '0, 1'b0, 1'b0, '0);

    // Error responses.
    cfg_bresp = 2'b10;
    wb_access(1'b1, 32'h30, 4'hF, 32'h55555555, 1'b1, 1'b0, '0);
    cfg_bresp = 2'b00; cfg_rresp = 2'b11; cfg_rforce = 1'b1; cfg_rdata = 32'h12345678;
    wb_access(1'b0, 32'h30, 4'h0, '0, 1'b1, 1'b1, 32'h12345678);
    cfg_rresp = 2'b00; cfg_rforce = 1'b0;
    wb_access(1'b0, 32'h30, 4'h0, '0, 1'b0, 1'b0, '0);

    // A write with no lanes selected is still issued and leaves memory alone.
    wb_access(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
    wb_access(1'b0, 32'h10, 4'h0, '0, 1'b0, 1'b0, '0);

    // Back-to-back: stb stays high across the first ack.
    drive(1'b0, 32'h00, 4'h0, '0);
    push_exp(1'b0, 32'h00, 4'h0, '0, 1'b0, 1'b0, '0);
    wait_resp(got);
    drive(1'b1, 32'h04, 4'hF, 32'h9ABCDEF0);
    push_exp(1'b1, 32'h04, 4'hF, 32'h9ABCDEF0, 1'b0, 1'b0, '0);
    wait_resp(got);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick();
    wb_access(1'b0, 32'h04, 4'h0, '0, 1'b0, 1'b0, '0);

    // Reset while AR is stalled.
    cfg_ar_lat = 1000;
    drive(1'b0, 32'h10, 4'h0, '0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_axil_arvalid) begin got = 1; break; end
    end
    check("stall_arvalid_seen", 32'(got), 32'd1);
    rst = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick();
    check_idle_outputs("midrst");
    tick();
    rst = 1'b0; cfg_ar_lat = 0; model_dat = '0;
    tick();
    wb_access(1'b0, 32'h10, 4'h0, '0, 1'b0, 1'b0, '0);
    repeat (3) tick();

    check("total_aw_hs", 32'(n_aw_hs), 32'(n_wr));
    check("total_w_hs",  32'(n_w_hs),  32'(n_wr));
    check("total_b_hs",  32'(n_b_hs),  32'(n_wr));
    check("total_ar_hs", 32'(n_ar_hs), 32'(n_rd));
    check("total_r_hs",  32'(n_r_hs),  32'(n_rd));
    check("sb_drained",  32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
